// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled UART receiver front end.
// Synchronizes rx, detects the start edge, majority-votes three mid-bit
// samples per bit and delivers one byte per frame with a single-cycle rdsig
// strobe plus aligned frame/parity error flags.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after DATA;
// sense chosen by PARITY_ODD). Default build is 8N1 with dataerror tied low.
module uart_rx_frontend #(
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rdsig,
    output logic       frameerror,
    output logic       dataerror,
    output logic       busy
);

    localparam int   DATA_W    = 8;
    localparam logic ODD_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t state, next_state;

    logic              rx_sync_p0;
    logic              rx_sync_p1;
    logic              rx_hist_p2;
    logic [1:0]        settle;
    logic              armed;
    logic [3:0]        tick;
    logic [2:0]        bit_idx;
    logic              samp7;
    logic              samp8;
    logic [DATA_W-1:0] shreg;
    logic              start_edge;
    logic              tick_mid;
    logic              tick_end;
    logic              bit_val;
    logic              stop_done;
    logic              parity_err;

    // Two of three samples agreeing decides the bit value.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick_mid   = (tick == 4'd9);
    assign tick_end   = (tick == 4'd15);
    assign bit_val    = majority3(samp7, samp8, rx_sync_p1);
    assign start_edge = (state == S_IDLE) && armed && rx_hist_p2 && !rx_sync_p1;
    assign stop_done  = (state == S_STOP) && tick_mid;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    assign parity_err = ((^shreg) ^ par_bit) != ODD_SENSE;

    // Capture the voted parity bit in the middle of the parity slot.
    always_ff @(posedge clk) begin
        if (state == S_PARITY && tick_mid)
            par_bit <= bit_val;
    end
`else
    // 8N1 framing carries no parity, so the sense setting has no effect.
    assign parity_err = 1'b0 & ODD_SENSE;
`endif

    // Two-flop synchronizer plus history flop; idle-high reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_hist_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
            rx_hist_p2 <= rx_sync_p1;
        end
    end

    // Arm start detection only once the flushed synchronizer has seen the
    // line high, so a line already low at reset release is not a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && rx_sync_p1)
                armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: bit slots end at tick 15, decisions fall at tick 9.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_edge) next_state = S_START;
            S_START: begin
                if (tick_mid && bit_val)
                    next_state = S_IDLE;
                else if (tick_end)
                    next_state = S_DATA;
            end
            S_DATA: begin
                if (tick_end && bit_idx == 3'(DATA_W - 1))
`ifdef UART_RX_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick_end) next_state = S_STOP;
`endif
            S_STOP:   if (tick_mid) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Tick and bit-index counters; the edge cycle itself is tick 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= 4'd0;
            bit_idx <= 3'd0;
        end else if (next_state == S_IDLE) begin
            tick    <= 4'd0;
            bit_idx <= 3'd0;
        end else begin
            tick <= tick + 4'd1;
            if (state == S_DATA && tick_end)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    // Mid-bit samples and LSB-first data shift register.
    always_ff @(posedge clk) begin
        if (tick == 4'd7)
            samp7 <= rx_sync_p1;
        if (tick == 4'd8)
            samp8 <= rx_sync_p1;
        if (state == S_DATA && tick_mid)
            shreg <= {bit_val, shreg[DATA_W-1:1]};
    end

    // Result strobe, error flags, held byte and busy indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxdata     <= 8'h00;
            rdsig      <= 1'b0;
            frameerror <= 1'b0;
            dataerror  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rdsig      <= stop_done;
            frameerror <= stop_done & ~bit_val;
            dataerror  <= stop_done & parity_err;
            busy       <= (state != S_IDLE) || (next_state != S_IDLE);
            if (stop_done)
                rxdata <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: scenario tasks plus a randomized frame stream checked
// against a frame-level reference model (byte, stop bit, parity count).
module tb_uart_rx_frontend;

    localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN     = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PAR_EN     = 1'b0;
    localparam int FRAME_BITS = 10;
`endif
    localparam int BIT_CLKS = 16;
    // rdsig follows the middle (tick 9) of the stop bit.
    localparam int LATENCY  = BIT_CLKS * (FRAME_BITS - 1) + 9;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rxdata;
    logic       rdsig;
    logic       frameerror;
    logic       dataerror;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int stray  = 0;

    int         rd_cyc[$];
    logic [7:0] rd_data[$];
    logic       rd_fe[$];
    logic       rd_de[$];
    int         busy_rise[$];
    int         busy_fall[$];
    logic       busy_q  = 1'b0;
    logic       rdsig_q = 1'b0;

    uart_rx_frontend #(.PARITY_ODD(PARITY_ODD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rxdata     (rxdata),
        .rdsig      (rdsig),
        .frameerror (frameerror),
        .dataerror  (dataerror),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the inactive edge.
    always @(negedge clk) begin
        busy_q  <= busy;
        rdsig_q <= rdsig;
        if (rdsig) begin
            rd_cyc.push_back(cyc);
            rd_data.push_back(rxdata);
            rd_fe.push_back(frameerror);
            rd_de.push_back(dataerror);
        end
        if (busy && !busy_q) busy_rise.push_back(cyc);
        if (!busy && busy_q) busy_fall.push_back(cyc);
        if ((!rdsig && (frameerror || dataerror)) || (rdsig && rdsig_q))
            stray <= stray + 1;
    end

    // ---------------- reference model helpers ----------------
    function automatic logic good_parity(input logic [7:0] d);
        return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ (PARITY_ODD != 0);
    endfunction

    function automatic logic model_de(input logic [7:0] d, input logic pbit);
        if (!PAR_EN) return 1'b0;
        return ((($countones(d) + int'(pbit)) % 2) != PARITY_ODD);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(pbit);
        drive_bit(stop_v);
    endtask

    task automatic clear_log();
        rd_cyc.delete();
        rd_data.delete();
        rd_fe.delete();
        rd_de.delete();
        busy_rise.delete();
        busy_fall.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        checks++; if (rxdata !== 8'h00) $display("FAIL reset_rxdata got %h want 00", rxdata); else passes++;
        checks++; if (rdsig !== 1'b0) $display("FAIL reset_rdsig got %b want 0", rdsig); else passes++;
        checks++; if (frameerror !== 1'b0) $display("FAIL reset_fe got %b want 0", frameerror); else passes++;
        checks++; if (dataerror !== 1'b0) $display("FAIL reset_de got %b want 0", dataerror); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        rst_n = 1'b1;
        wait_clks(6);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passes++;
        checks++; if (rdsig !== 1'b0) $display("FAIL idle_rdsig got %b want 0", rdsig); else passes++;
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(8'h48, 1'b1, good_parity(8'h48));
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 1) $display("FAIL basic_count got %0d want 1", rd_cyc.size()); else passes++;
        if (rd_cyc.size() >= 1 && busy_rise.size() >= 1) begin
            checks++; if (rd_data[0] !== 8'h48) $display("FAIL basic_data got %h want 48", rd_data[0]); else passes++;
            checks++; if (rd_fe[0] !== 1'b0) $display("FAIL basic_fe got %b want 0", rd_fe[0]); else passes++;
            checks++; if (rd_de[0] !== 1'b0) $display("FAIL basic_de got %b want 0", rd_de[0]); else passes++;
            checks++;
            if (rd_cyc[0] - busy_rise[0] !== LATENCY)
                $display("FAIL basic_latency got %0d want %0d", rd_cyc[0] - busy_rise[0], LATENCY);
            else passes++;
        end
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 0) $display("FAIL glitch_rdsig got %0d want 0", rd_cyc.size()); else passes++;
        checks++; if (busy_rise.size() !== 1) $display("FAIL glitch_busy_rise got %0d want 1", busy_rise.size()); else passes++;
        if (busy_rise.size() == 1 && busy_fall.size() >= 1) begin
            checks++;
            if (busy_fall[0] - busy_rise[0] !== 10)
                $display("FAIL glitch_busy_len got %0d want 10", busy_fall[0] - busy_rise[0]);
            else passes++;
        end else begin
            checks++; $display("FAIL glitch_busy_len got no pulse want 10");
        end
    endtask

    task automatic test_frame_error();
        clear_log();
        send_frame(8'h55, 1'b0, good_parity(8'h55));
        rx = 1'b0;
        wait_clks(200);
        rx = 1'b1;
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 1) $display("FAIL ferr_count got %0d want 1", rd_cyc.size()); else passes++;
        checks++; if (busy_rise.size() !== 1) $display("FAIL break_busy got %0d want 1", busy_rise.size()); else passes++;
        if (rd_cyc.size() >= 1) begin
            checks++; if (rd_data[0] !== 8'h55) $display("FAIL ferr_data got %h want 55", rd_data[0]); else passes++;
            checks++; if (rd_fe[0] !== 1'b1) $display("FAIL ferr_flag got %b want 1", rd_fe[0]); else passes++;
        end
        clear_log();
        send_frame(8'hA3, 1'b1, good_parity(8'hA3));
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 1) $display("FAIL recover_count got %0d want 1", rd_cyc.size()); else passes++;
        if (rd_cyc.size() >= 1) begin
            checks++; if (rd_data[0] !== 8'hA3) $display("FAIL recover_data got %h want a3", rd_data[0]); else passes++;
            checks++; if (rd_fe[0] !== 1'b0) $display("FAIL recover_fe got %b want 0", rd_fe[0]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h41, 1'b1, good_parity(8'h41));
        send_frame(8'h37, 1'b1, good_parity(8'h37));
        rx = 1'b1;
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 2) $display("FAIL b2b_count got %0d want 2", rd_cyc.size()); else passes++;
        if (rd_cyc.size() >= 2) begin
            checks++; if (rd_data[0] !== 8'h41) $display("FAIL b2b_data0 got %h want 41", rd_data[0]); else passes++;
            checks++; if (rd_data[1] !== 8'h37) $display("FAIL b2b_data1 got %h want 37", rd_data[1]); else passes++;
            checks++;
            if (rd_cyc[1] - rd_cyc[0] !== BIT_CLKS * FRAME_BITS)
                $display("FAIL b2b_spacing got %0d want %0d", rd_cyc[1] - rd_cyc[0], BIT_CLKS * FRAME_BITS);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h2C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        wait_clks(8);
        rst_n = 1'b0;
        wait_clks(1);
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passes++;
        checks++; if (rxdata !== 8'h00) $display("FAIL midrst_rxdata got %h want 00", rxdata); else passes++;
        checks++; if ({rdsig, frameerror, dataerror} !== 3'b000) $display("FAIL midrst_flags got %b want 000", {rdsig, frameerror, dataerror}); else passes++;
        wait_clks(2);
        rst_n = 1'b1;
        clear_log();
        wait_clks(30);
        checks++; if (busy_rise.size() !== 0) $display("FAIL lowline_start got %0d want 0", busy_rise.size()); else passes++;
        checks++; if (rd_cyc.size() !== 0) $display("FAIL midrst_rdsig got %0d want 0", rd_cyc.size()); else passes++;
        rx = 1'b1;
        wait_clks(20);
        clear_log();
        send_frame(8'h0D, 1'b1, good_parity(8'h0D));
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 1) $display("FAIL after_rst_count got %0d want 1", rd_cyc.size()); else passes++;
        if (rd_cyc.size() >= 1 && busy_rise.size() >= 1) begin
            checks++; if (rd_data[0] !== 8'h0D) $display("FAIL after_rst_data got %h want 0d", rd_data[0]); else passes++;
            checks++;
            if (rd_cyc[0] - busy_rise[0] !== LATENCY)
                $display("FAIL after_rst_latency got %0d want %0d", rd_cyc[0] - busy_rise[0], LATENCY);
            else passes++;
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_log();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(40);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(40);
        checks++; if (rd_cyc.size() !== 2) $display("FAIL par_count got %0d want 2", rd_cyc.size()); else passes++;
        if (rd_cyc.size() >= 2 && busy_rise.size() >= 2) begin
            checks++; if (rd_de[0] !== model_de(8'h07, 1'b1)) $display("FAIL par_ok_de got %b want %b", rd_de[0], model_de(8'h07, 1'b1)); else passes++;
            checks++; if (rd_de[1] !== model_de(8'h07, 1'b0)) $display("FAIL par_bad_de got %b want %b", rd_de[1], model_de(8'h07, 1'b0)); else passes++;
            checks++; if (rd_data[1] !== 8'h07) $display("FAIL par_data got %h want 07", rd_data[1]); else passes++;
            checks++;
            if (rd_cyc[1] - busy_rise[1] !== LATENCY)
                $display("FAIL par_latency got %0d want %0d", rd_cyc[1] - busy_rise[1], LATENCY);
            else passes++;
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_data[$];
        logic       exp_fe[$];
        logic       exp_de[$];
        logic [7:0] d;
        logic       stop_v;
        logic       pbit;
        int         gap;
        int         n;
        clear_log();
        for (int k = 0; k < 24; k++) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 7) != 0);
            pbit   = good_parity(d) ^ (PAR_EN && ($urandom_range(0, 3) == 0));
            gap    = stop_v ? $urandom_range(0, 12) : $urandom_range(2, 12);
            send_frame(d, stop_v, pbit);
            rx = 1'b1;
            if (gap > 0) wait_clks(gap);
            exp_data.push_back(d);
            exp_fe.push_back(!stop_v);
            exp_de.push_back(model_de(d, pbit));
        end
        wait_clks(40);
        checks++; if (rd_cyc.size() !== exp_data.size()) $display("FAIL rand_count got %0d want %0d", rd_cyc.size(), exp_data.size()); else passes++;
        n = (rd_cyc.size() < exp_data.size()) ? rd_cyc.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (rd_data[i] !== exp_data[i]) $display("FAIL rand_data[%0d] got %h want %h", i, rd_data[i], exp_data[i]); else passes++;
            checks++; if (rd_fe[i] !== exp_fe[i]) $display("FAIL rand_fe[%0d] got %b want %b", i, rd_fe[i], exp_fe[i]); else passes++;
            checks++; if (rd_de[i] !== exp_de[i]) $display("FAIL rand_de[%0d] got %b want %b", i, rd_de[i], exp_de[i]); else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        checks++; if (stray !== 0) $display("FAIL stray_flags got %0d want 0", stray); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
